conv_feed_ctrl: RTL and testbench
=================================

Name: conv_feed_ctrl

Overview:
- Sequencer that drives the first-layer convolution datapath (`chip`) from an on-chip input buffer and weight store.
- Phase 1 loads weights: 4 filter columns x 3 PEA rows, 12 beats, filter column outer, PEA row inner.
- Phase 2 issues input-pixel read addresses in the serpentine order the PE array expects.
  - Rows 0 and 1 are column-interleaved, left to right.
  - From row 2 on, rows alternate direction: even rows right-to-left, odd rows left-to-right.
- Sits between the top-level start/done control and the buffer read ports. One frame per start.

Parameters:
- ROW, 128, input rows per frame (>=3).
- COL, 128, input columns per frame (>=2).
- ADDR_W, 14, buffer address width; must satisfy 2^ADDR_W >= ROW*COL.
- FCOL_N, 4, weight filter columns.
- PROW_N, 3, weight PEA rows.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  frame start request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- in_ready  in  1  buffer/datapath can accept a beat this cycle.
- w_en  out  1  weight beat valid.
- w_fcol  out  2  weight filter-column index.
- w_prow  out  2  weight PEA-row index.
- rd_en  out  1  pixel read beat valid.
- rd_row  out  $clog2(ROW)  pixel row.
- rd_col  out  $clog2(COL)  pixel column.
- rd_addr  out  ADDR_W  rd_row*COL+rd_col.
- dir  out  1  PE shift direction: 0 = right (left-to-right), 1 = left.
- row_first  out  1  first beat of a serpentine row (row >= 2).
- last  out  1  final pixel beat of the frame.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on frame completion.

Behaviour:
- Reset: state=IDLE; all counters 0; every output 0.
- States and transitions:
  - IDLE: start -> WLOAD.
  - WLOAD: 12 beats, then -> PRIME.
  - PRIME: 2*COL beats, then -> SNAKE.
  - SNAKE: (ROW-2)*COL beats, then -> FIN.
  - FIN: done=1 for one cycle -> IDLE.
- Beat rule: one beat is issued per cycle in which the state is WLOAD, PRIME or SNAKE and in_ready=1.
  - w_en / rd_en equal (phase) & in_ready, combinationally.
  - Index outputs are registered counters and stay stable while in_ready=0.
  - Counters advance only on a beat.
- WLOAD order: (fcol,prow) = (0,0),(0,1),(0,2),(1,0)...(3,2). The transition fires on the beat at (3,2).
- PRIME order: (r,c) = (0,0),(1,0),(0,1),(1,1)...(1,COL-1). dir=0. row_first=0.
- SNAKE order:
  - Row r = 2..ROW-1.
  - Even r: c = COL-1 down to 0, dir=1.
  - Odd r: c = 0 to COL-1, dir=0.
  - row_first=1 on the first beat of each row.
- last: 1 on the beat at r=ROW-1 with c=0 if ROW-1 is even, c=COL-1 if ROW-1 is odd.
- Latency, no stalls:
  - start in cycle T -> first w_en in T+1.
  - First rd_en in T+13.
  - last in T+12+ROW*COL.
  - done in T+13+ROW*COL.
- Boundary conditions:
  - start while busy: ignored.
  - start and abort together in IDLE: abort wins, stay IDLE.
  - abort in any busy state: next cycle IDLE, counters cleared, no done pulse.
  - in_ready low on the final beat: last and the state both hold until the beat is taken.
  - Asynchronous reset mid-frame: immediate return to reset values.
- Width rules:
  - rd_addr is computed from the registered row and column counters.
  - If rd_addr is held in its own counter, it increments by 1 (PRIME second row +COL handled by mux), ±1 in SNAKE, and must equal rd_row*COL+rd_col.

Decomposition:
- Shared para.v package holds ROW_first_layer/COL_first_layer defaults, FCOL_N, PROW_N, and the state encodings (IDLE, WLOAD, PRIME, SNAKE, FIN).
- One natural sub-module: serp_addr_gen.
  - Contains the row/col counters, dir, row_first and last.
  - Has an enable input and a prime/snake mode input.
- The FSM and weight counter stay in the top module.

Test Plan:
- ROW=4, COL=4, in_ready=1, pulse start:
  - 12 w_en beats (0,0)..(3,2).
  - Then rd beats (0,0),(1,0),(0,1),(1,1),(0,2),(1,2),(0,3),(1,3).
  - Then (2,3),(2,2),(2,1),(2,0),(3,0),(3,1),(3,2),(3,3).
  - last on (3,3); done 1 cycle later; 28 beats total.
- Same config with in_ready toggled 1,0,1,0:
  - Beat sequence identical.
  - Outputs frozen and rd_en/w_en=0 in every ready-low cycle.
  - done at T+13+16+stall_cycles.
- ROW=5, COL=3:
  - The final row (r=4, even) runs c=2,1,0 with dir=1.
  - last on rd_addr=12.
- abort asserted on the 5th PRIME beat: next cycle busy=0, all outputs 0, no done.
  - A new start then gives a full frame starting at WLOAD (0,0).
- start re-pulsed during SNAKE: no effect, sequence unchanged.
- rst_n dropped mid-WLOAD: outputs 0 asynchronously (before the next clk edge). After release the block is IDLE until start.

Source files
------------

// File: rtl/conv_feed_ctrl_pkg.sv
// rtl/conv_feed_ctrl_pkg.sv - shared defaults and state encoding for the first-layer feed sequencer
package conv_feed_ctrl_pkg;

  localparam int ROW_first_layer    = 128;
  localparam int COL_first_layer    = 128;
  localparam int ADDR_W_first_layer = 14;
  localparam int FCOL_N             = 4;
  localparam int PROW_N             = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WLOAD = 3'd1,
    ST_PRIME = 3'd2,
    ST_SNAKE = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/conv_feed_ctrl_serp_addr_gen.sv
// rtl/conv_feed_ctrl_serp_addr_gen.sv - pixel row/col/address walker for the interleaved prime rows and serpentine rows
module conv_feed_ctrl_serp_addr_gen
  import conv_feed_ctrl_pkg::*;
#(
  parameter int ROW    = ROW_first_layer,
  parameter int COL    = COL_first_layer,
  parameter int ADDR_W = ADDR_W_first_layer,
  parameter int RW     = $clog2(ROW),
  parameter int CW     = $clog2(COL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              snake,
  output logic [RW-1:0]     row,
  output logic [CW-1:0]     col,
  output logic [ADDR_W-1:0] addr,
  output logic              dir,
  output logic              row_first,
  output logic              last,
  output logic              prime_end
);

  localparam logic [RW-1:0]     ROW_LAST = RW'(ROW - 1);
  localparam logic [CW-1:0]     COL_LAST = CW'(COL - 1);
  localparam logic [ADDR_W-1:0] COL_A    = ADDR_W'(COL);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  logic col_is_first;

  // Even serpentine rows run right-to-left, so their first column is the rightmost one.
  assign col_is_first = row[0] ? (col == '0) : (col == COL_LAST);
  assign dir          = snake & ~row[0];
  assign row_first    = snake & col_is_first;
  assign last         = snake & (row == ROW_LAST) & (row[0] ? (col == COL_LAST) : (col == '0));
  assign prime_end    = ~snake & (row == RW'(1)) & (col == COL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (clr) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (en) begin
      if (!snake) begin
        if (row == '0) begin
          row  <= RW'(1);
          addr <= addr + COL_A;
        end else if (col == COL_LAST) begin
          // Leaving prime: row 2 is even and starts at the column we are already on.
          row  <= RW'(2);
          addr <= addr + COL_A;
        end else begin
          row  <= '0;
          col  <= col + CW'(1);
          addr <= addr - COL_A + ONE_A;
        end
      end else if (last) begin
        row  <= '0;
        col  <= '0;
        addr <= '0;
      end else if (!row[0]) begin
        if (col == '0) begin
          row  <= row + RW'(1);
          addr <= addr + COL_A;
        end else begin
          col  <= col - CW'(1);
          addr <= addr - ONE_A;
        end
      end else begin
        if (col == COL_LAST) begin
          row  <= row + RW'(1);
          addr <= addr + COL_A;
        end else begin
          col  <= col + CW'(1);
          addr <= addr + ONE_A;
        end
      end
    end
  end

endmodule

// File: rtl/conv_feed_ctrl.sv
// rtl/conv_feed_ctrl.sv - first-layer conv feed sequencer: weight load, then serpentine pixel read addresses
module conv_feed_ctrl
  import conv_feed_ctrl_pkg::*;
#(
  parameter int ROW    = ROW_first_layer,
  parameter int COL    = COL_first_layer,
  parameter int ADDR_W = ADDR_W_first_layer,
  parameter int FCOL_N = conv_feed_ctrl_pkg::FCOL_N,
  parameter int PROW_N = conv_feed_ctrl_pkg::PROW_N
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_ready,
  output logic                   w_en,
  output logic [1:0]             w_fcol,
  output logic [1:0]             w_prow,
  output logic                   rd_en,
  output logic [$clog2(ROW)-1:0] rd_row,
  output logic [$clog2(COL)-1:0] rd_col,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic                   dir,
  output logic                   row_first,
  output logic                   last,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] FCOL_LAST = 2'(FCOL_N - 1);
  localparam logic [1:0] PROW_LAST = 2'(PROW_N - 1);

  state_t state;
  logic   rd_phase;
  logic   prime_end;

  assign rd_phase = (state == ST_PRIME) || (state == ST_SNAKE);
  assign w_en     = (state == ST_WLOAD) & in_ready;
  assign rd_en    = rd_phase & in_ready;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FIN);

  conv_feed_ctrl_serp_addr_gen #(
    .ROW    (ROW),
    .COL    (COL),
    .ADDR_W (ADDR_W)
  ) u_serp (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (abort),
    .en        (rd_en),
    .snake     (state == ST_SNAKE),
    .row       (rd_row),
    .col       (rd_col),
    .addr      (rd_addr),
    .dir       (dir),
    .row_first (row_first),
    .last      (last),
    .prime_end (prime_end)
  );

  // Transitions only fire on a taken beat, so a stalled final beat keeps both state and last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      w_fcol <= '0;
      w_prow <= '0;
    end else if (abort) begin
      state  <= ST_IDLE;
      w_fcol <= '0;
      w_prow <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_WLOAD;
        end
        ST_WLOAD: begin
          if (in_ready) begin
            if (w_prow == PROW_LAST) begin
              w_prow <= '0;
              if (w_fcol == FCOL_LAST) begin
                w_fcol <= '0;
                state  <= ST_PRIME;
              end else begin
                w_fcol <= w_fcol + 2'd1;
              end
            end else begin
              w_prow <= w_prow + 2'd1;
            end
          end
        end
        ST_PRIME: begin
          if (in_ready && prime_end) state <= ST_SNAKE;
        end
        ST_SNAKE: begin
          if (in_ready && last) state <= ST_FIN;
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_feed_ctrl.sv
// tb/tb_conv_feed_ctrl.sv - scoreboard bench for conv_feed_ctrl (4x4 and 5x3 frames)
module tb_conv_feed_ctrl;

  typedef struct packed {
    logic        is_w;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] addr;
    logic        dir;
    logic        rf;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic       rst_n;
  logic       start_a, abort_a, in_ready_a;
  logic       w_en_a, rd_en_a, dir_a, row_first_a, last_a, busy_a, done_a;
  logic [1:0] w_fcol_a, w_prow_a, rd_row_a, rd_col_a;
  logic [7:0] rd_addr_a;

  logic       start_b, abort_b, in_ready_b;
  logic       w_en_b, rd_en_b, dir_b, row_first_b, last_b, busy_b, done_b;
  logic [1:0] w_fcol_b, w_prow_b, rd_col_b;
  logic [2:0] rd_row_b;
  logic [3:0] rd_addr_b;

  conv_feed_ctrl #(.ROW(4), .COL(4), .ADDR_W(8), .FCOL_N(4), .PROW_N(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .in_ready(in_ready_a),
    .w_en(w_en_a), .w_fcol(w_fcol_a), .w_prow(w_prow_a), .rd_en(rd_en_a),
    .rd_row(rd_row_a), .rd_col(rd_col_a), .rd_addr(rd_addr_a), .dir(dir_a),
    .row_first(row_first_a), .last(last_a), .busy(busy_a), .done(done_a)
  );

  conv_feed_ctrl #(.ROW(5), .COL(3), .ADDR_W(4), .FCOL_N(4), .PROW_N(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .in_ready(in_ready_b),
    .w_en(w_en_b), .w_fcol(w_fcol_b), .w_prow(w_prow_b), .rd_en(rd_en_b),
    .rd_row(rd_row_b), .rd_col(rd_col_b), .rd_addr(rd_addr_b), .dir(dir_b),
    .row_first(row_first_b), .last(last_b), .busy(busy_b), .done(done_b)
  );

  beat_t exp_frame[$];
  beat_t q_a[$];
  beat_t q_b[$];

  int done_cnt_a = 0, done_cyc_a = 0, first_rd_a = 0, last_cyc_a = 0, beats_a = 0, stalls_a = 0;
  int done_cnt_b = 0, done_cyc_b = 0, last_addr_b = 0;
  logic        prev_stall_a = 1'b0;
  logic [18:0] snap_a, prev_snap_a;
  int t0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic is_w, input int a, input int b, input int addr,
                               input logic dir, input logic rf, input logic last);
    beat_t t;
    t.is_w = is_w;
    t.a    = a[7:0];
    t.b    = b[7:0];
    t.addr = addr[15:0];
    t.dir  = dir;
    t.rf   = rf;
    t.last = last;
    return t;
  endfunction

  // Independent reference order: weights, interleaved rows 0/1, then serpentine rows.
  task automatic gen_frame(input int r_n, input int c_n);
    exp_frame.delete();
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < 3; p++)
        exp_frame.push_back(mk(1'b1, f, p, 0, 1'b0, 1'b0, 1'b0));
    for (int c = 0; c < c_n; c++) begin
      exp_frame.push_back(mk(1'b0, 0, c, c, 1'b0, 1'b0, 1'b0));
      exp_frame.push_back(mk(1'b0, 1, c, c_n + c, 1'b0, 1'b0, 1'b0));
    end
    for (int r = 2; r < r_n; r++)
      for (int k = 0; k < c_n; k++) begin
        int c;
        c = (r % 2 == 0) ? (c_n - 1 - k) : k;
        exp_frame.push_back(mk(1'b0, r, c, r * c_n + c, (r % 2 == 0), (k == 0),
                               (r == r_n - 1) && (k == c_n - 1)));
      end
  endtask

  task automatic compare_beat(input string tag, input beat_t obs, input beat_t e);
    check({tag, "_kind"}, obs.is_w, e.is_w);
    check({tag, "_a"}, obs.a, e.a);
    check({tag, "_b"}, obs.b, e.b);
    if (!e.is_w) begin
      check({tag, "_addr"}, obs.addr, e.addr);
      check({tag, "_dir"}, obs.dir, e.dir);
      check({tag, "_row_first"}, obs.rf, e.rf);
      check({tag, "_last"}, obs.last, e.last);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    snap_a = {w_fcol_a, w_prow_a, rd_row_a, rd_col_a, rd_addr_a, dir_a, row_first_a, last_a};
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
    if (rd_en_a && rd_row_a == 2'd0 && rd_col_a == 2'd0) first_rd_a = cyc;
    if (rd_en_a && last_a) last_cyc_a = cyc;
    if (w_en_a && rd_en_a) check("a_both_en", 1, 0);
    if (w_en_a || rd_en_a) begin
      beats_a++;
      if (q_a.size() == 0) check("a_unexpected_beat", 1, 0);
      else begin
        e = q_a.pop_front();
        compare_beat("a_beat", mk(w_en_a, w_en_a ? int'(w_fcol_a) : int'(rd_row_a),
                     w_en_a ? int'(w_prow_a) : int'(rd_col_a), int'(rd_addr_a),
                     dir_a, row_first_a, last_a), e);
      end
    end
    if (prev_stall_a && busy_a) check("a_stall_hold", snap_a, prev_snap_a);
    if (busy_a && !done_a && !in_ready_a) begin
      stalls_a++;
      check("a_stall_w_en", w_en_a, 0);
      check("a_stall_rd_en", rd_en_a, 0);
    end
    prev_stall_a = busy_a && !done_a && !in_ready_a;
    prev_snap_a  = snap_a;
  end

  always @(negedge clk) begin
    beat_t e;
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
    if (rd_en_b && last_b) last_addr_b = int'(rd_addr_b);
    if (w_en_b || rd_en_b) begin
      if (q_b.size() == 0) check("b_unexpected_beat", 1, 0);
      else begin
        e = q_b.pop_front();
        compare_beat("b_beat", mk(w_en_b, w_en_b ? int'(w_fcol_b) : int'(rd_row_b),
                     w_en_b ? int'(w_prow_b) : int'(rd_col_b), int'(rd_addr_b),
                     dir_b, row_first_b, last_b), e);
      end
    end
    if (!busy_b && (w_en_b || rd_en_b)) check("b_idle_beat", 1, 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int target);
    for (int i = 0; i < 200 && cyc < target; i++) step();
    check("step_to_reached", cyc, target);
  endtask

  task automatic start_frame_a();
    gen_frame(4, 4);
    step();
    start_a = 1'b1;
    t0 = cyc;
    q_a = exp_frame;
    step();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int rel, input logic toggle, input int stall0);
    int c0;
    c0 = done_cnt_a;
    for (int i = 0; i < 300 && done_cnt_a == c0; i++) begin
      step();
      if (toggle) in_ready_a = ~in_ready_a;
    end
    in_ready_a = 1'b1;
    check({tag, "_done_seen"}, done_cnt_a - c0, 1);
    check({tag, "_done_cycle"}, done_cyc_a - t0, rel + (stalls_a - stall0));
  endtask

  initial begin
    int b0, s0, d0, c0;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; in_ready_a = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; in_ready_b = 1'b1;
    step(); step();
    check("reset_outputs_a", {w_en_a, w_fcol_a, w_prow_a, rd_en_a, rd_row_a, rd_col_a, rd_addr_a,
                              dir_a, row_first_a, last_a, busy_a, done_a}, 0);
    check("reset_busy_b", busy_b, 0);
    rst_n = 1'b1;
    step(); step();
    check("idle_after_reset", busy_a, 0);

    // Full 4x4 frame, always ready.
    b0 = beats_a;
    start_frame_a();
    wait_done_a("f1", 29, 1'b0, stalls_a);
    check("f1_first_rd", first_rd_a - t0, 13);
    check("f1_last_cycle", last_cyc_a - t0, 28);
    check("f1_beats", beats_a - b0, 28);
    check("f1_queue_empty", q_a.size(), 0);

    // Ready toggling every cycle.
    s0 = stalls_a;
    start_frame_a();
    wait_done_a("f2", 29, 1'b1, s0);
    check("f2_stalled", (stalls_a - s0) > 0, 1);
    check("f2_queue_empty", q_a.size(), 0);

    // start re-pulsed mid-SNAKE, then the final beat is stalled for three cycles.
    s0 = stalls_a;
    start_frame_a();
    step_to(t0 + 22);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step_to(t0 + 28);
    in_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("f3_last_held", last_a, 1);
      check("f3_no_early_done", done_a, 0);
      step();
      if (i < 2) in_ready_a = 1'b0;
    end
    in_ready_a = 1'b1;
    wait_done_a("f3", 29, 1'b0, s0);
    check("f3_queue_empty", q_a.size(), 0);

    // Abort on the 5th PRIME beat.
    start_frame_a();
    step_to(t0 + 17);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    q_a.delete();
    #1;
    check("abort_outputs", {w_en_a, w_fcol_a, w_prow_a, rd_en_a, rd_row_a, rd_col_a, rd_addr_a,
                            dir_a, row_first_a, last_a, busy_a, done_a}, 0);
    d0 = done_cnt_a;
    repeat (40) step();
    check("abort_no_done", done_cnt_a - d0, 0);
    start_frame_a();
    wait_done_a("f4", 29, 1'b0, stalls_a);
    check("f4_queue_empty", q_a.size(), 0);

    // start and abort together in IDLE.
    start_a = 1'b1; abort_a = 1'b1;
    step();
    start_a = 1'b0; abort_a = 1'b0;
    step();
    check("start_abort_idle", busy_a, 0);

    // Asynchronous reset mid-WLOAD.
    start_frame_a();
    step_to(t0 + 5);
    check("pre_reset_fcol", w_fcol_a, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {w_en_a, w_fcol_a, w_prow_a, busy_a}, 0);
    q_a.delete();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("post_reset_idle", {busy_a, w_en_a}, 0);

    // 5x3 frame on the second instance.
    gen_frame(5, 3);
    step();
    start_b = 1'b1;
    t0 = cyc;
    q_b = exp_frame;
    step();
    start_b = 1'b0;
    c0 = done_cnt_b;
    for (int i = 0; i < 300 && done_cnt_b == c0; i++) step();
    check("b_done_seen", done_cnt_b - c0, 1);
    check("b_done_cycle", done_cyc_b - t0, 28);
    check("b_last_addr", last_addr_b, 12);
    check("b_queue_empty", q_b.size(), 0);
    check("a_queue_final", q_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
